// File: rtl/regfile_muxrd.sv
// regfile_muxrd: register bank with muxn-selected read ports, one write port and a sequential clear engine.
module muxn #(
  parameter int NB_SEL = 3
) (
  input  logic [2**NB_SEL-1:0] din,
  input  logic [NB_SEL-1:0]    sel,
  output logic                 dout
);
  assign dout = din[sel];
endmodule

module regfile_muxrd #(
  parameter int NB_SEL   = 3,
  parameter int WIDTH    = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [NB_SEL-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [NB_SEL-1:0] rd_addr_a,
  input  logic [NB_SEL-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);
  localparam int N = 2**NB_SEL;
  localparam logic [NB_SEL-1:0] LAST = NB_SEL'(N - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state, state_nx;
  logic [NB_SEL-1:0] cnt;
  logic [WIDTH-1:0] mem [N];
  logic [N-1:0] col [WIDTH];
  logic [WIDTH-1:0] mux_a, mux_b;
  logic wr_ok;
  // Register 0 is never written when hardwired, so it reads 0 through the mux as well.
  assign wr_ok = wr_en && state == IDLE && !(ZERO_REG != 0 && wr_addr == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state == CLEAR) ? cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)  ? (clr_req ? CLEAR : IDLE) :
               (state == CLEAR) ? ((cnt == LAST) ? DONE : CLEAR) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_ok && !clr_req) begin
      mem[wr_addr] <= wr_data;
    end
  end
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    for (genvar i = 0; i < N; i++) begin : g_col
      assign col[b][i] = mem[i][b];
    end
    muxn #(.NB_SEL(NB_SEL)) u_mux_a (.din(col[b]), .sel(rd_addr_a), .dout(mux_a[b]));
    muxn #(.NB_SEL(NB_SEL)) u_mux_b (.din(col[b]), .sel(rd_addr_b), .dout(mux_b[b]));
  end
  assign rd_data_a = (BYPASS != 0 && wr_ok && rd_addr_a == wr_addr) ? wr_data : mux_a;
  assign rd_data_b = (BYPASS != 0 && wr_ok && rd_addr_b == wr_addr) ? wr_data : mux_b;
  assign busy = state == CLEAR;
  assign clr_done = state == DONE;
endmodule

// File: tb/tb_regfile_muxrd.sv
// tb_regfile_muxrd: vector table, clear/reset sequences and random traffic against a reference model.
module tb_regfile_muxrd;
  logic clk = 1'b0;
  logic rst_n, wr_en, clr_req, busy, clr_done;
  logic [2:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data, rd_data_a, rd_data_b;
  int vectors = 0, miscompares = 0;
  int m [8];
  int phase;
  regfile_muxrd dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic we; logic [2:0] wa; logic [7:0] wd; logic [2:0] ra; logic [2:0] rb;
    logic [7:0] ea; logic [7:0] eb;
  } vec_t;
  vec_t tbl [8];
  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask
  // Model: phase -1 idle, 0..7 clearing that register this cycle, 8 done pulse.
  function automatic int exp_rd(input int a);
    if (a == 0) return 0;
    if (wr_en && phase == -1 && a == int'(wr_addr)) return int'(wr_data);
    return m[a];
  endfunction
  task automatic model_reset();
    foreach (m[i]) m[i] = 0;
    phase = -1;
  endtask
  task automatic model_edge();
    if (phase == -1) begin
      if (clr_req) phase = 0;
      else if (wr_en && wr_addr != 0) m[wr_addr] = int'(wr_data);
    end else if (phase < 8) begin
      m[phase] = 0;
      phase++;
    end else phase = -1;
  endtask
  task automatic compare_all();
    check("rd_data_a", int'(rd_data_a), exp_rd(int'(rd_addr_a)));
    check("rd_data_b", int'(rd_data_b), exp_rd(int'(rd_addr_b)));
    check("busy", int'(busy), int'(phase >= 0 && phase < 8));
    check("clr_done", int'(clr_done), int'(phase == 8));
  endtask
  task automatic cyc();
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'(d);
    cyc();
    wr_en = 1'b0;
  endtask
  initial begin
    int busy_n, done_n;
    tbl[0] = '{1, 3, 8'hA5, 3, 0, 8'hA5, 8'h00};
    tbl[1] = '{1, 7, 8'h3C, 3, 7, 8'hA5, 8'h3C};
    tbl[2] = '{1, 0, 8'hFF, 0, 7, 8'h00, 8'h3C};
    tbl[3] = '{0, 0, 8'h00, 0, 3, 8'h00, 8'hA5};
    tbl[4] = '{1, 5, 8'h11, 5, 5, 8'h11, 8'h11};
    tbl[5] = '{1, 5, 8'h5A, 5, 3, 8'h5A, 8'hA5};
    tbl[6] = '{0, 5, 8'h00, 5, 5, 8'h5A, 8'h5A};
    tbl[7] = '{1, 2, 8'h77, 1, 2, 8'h00, 8'h77};
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      #1;
      check("reset_rd", int'(rd_data_a), 0);
      cyc();
    end
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(clr_done), 0);
    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
      #1;
      check("tbl_a", int'(rd_data_a), int'(tbl[i].ea));
      check("tbl_b", int'(rd_data_b), int'(tbl[i].eb));
      cyc();
    end
    wr_en = 1'b0;
    for (int k = 1; k < 8; k++) wr(k, k * 16);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 20; c++) begin
      wr_en = phase == 7; wr_addr = 3'd6; wr_data = 8'h99;
      clr_req = phase == 3 || phase == 8;
      rd_addr_a = 3'(c % 8); rd_addr_b = 3'(7 - c % 8);
      #1;
      busy_n += int'(busy);
      done_n += int'(clr_done);
      cyc();
    end
    wr_en = 1'b0; clr_req = 1'b0;
    check("clear_busy_cycles", busy_n, 8);
    check("clear_done_pulses", done_n, 1);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      #1;
      check("after_clear_rd", int'(rd_data_a), 0);
    end
    for (int k = 4; k < 8; k++) wr(k, 8'h40 + k);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (4) cyc();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(clr_done), 0);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a); rd_addr_b = 3'(7 - a);
      #1;
      compare_all();
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) begin
      rd_addr_a = 3'($urandom_range(7));
      cyc();
    end
    wr(4, 8'h4D);
    rd_addr_a = 3'd4;
    #1;
    check("post_reset_write", int'(rd_data_a), 8'h4D);
    for (int c = 0; c < 400; c++) begin
      wr_en = 1'($urandom_range(1));
      wr_addr = 3'($urandom);
      wr_data = 8'($urandom);
      rd_addr_a = 3'($urandom);
      rd_addr_b = ($urandom_range(7) == 0) ? rd_addr_a : 3'($urandom);
      clr_req = $urandom_range(19) == 0;
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_muxrd.md
Name: regfile_muxrd

Overview:
- Register bank of 2**NB_SEL words, WIDTH bits each. It is the storage stage directly upstream of the muxn read selector.
- Holds CPU general-purpose registers. Two read ports are resolved through per-bit muxn selection; one synchronous write port is provided.
- A sequential clear engine zeros the whole bank on request, one register per cycle, and reports busy while doing so.

Parameters:
- NB_SEL, 3: address width; the bank holds 2**NB_SEL registers.
- WIDTH, 8: data width of each register.
- ZERO_REG, 1: when 1, register 0 always reads 0 and ignores writes.
- BYPASS, 1: when 1, a read that hits the address being written this cycle returns the write data.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  NB_SEL  write address.
- wr_data  in  WIDTH  write data.
- rd_addr_a  in  NB_SEL  read port A address.
- rd_addr_b  in  NB_SEL  read port B address.
- rd_data_a  out  WIDTH  read port A data (combinational).
- rd_data_b  out  WIDTH  read port B data (combinational).
- clr_req  in  1  one-cycle pulse that starts a bank clear.
- busy  out  1  high while a clear is in progress.
- clr_done  out  1  one-cycle pulse in the cycle after the last register is cleared.

Behaviour:
- Reset (rst_n low, async):
  - All registers go to 0.
  - FSM goes to IDLE; clear counter goes to 0.
  - busy=0, clr_done=0.
  - rd_data_a/b therefore read 0.
- Read:
  - Combinational, zero latency. rd_data_x = reg[rd_addr_x].
  - Each bit is selected by a muxn instance with NB_SEL=NB_SEL.
- Write:
  - On the rising clk edge when wr_en=1 and state=IDLE, reg[wr_addr] <= wr_data.
  - New data is visible on reads in the cycle after the edge, unless bypass applies.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0. Bypass never applies to address 0.
- BYPASS=1:
  - When wr_en=1, state=IDLE and rd_addr_x==wr_addr (and not zero-reg), rd_data_x = wr_data in the same cycle.
  - With BYPASS=0, reads return the old value until the edge.
- FSM states:
  - IDLE:
    - clr_req=1 -> CLEAR, counter <= 0.
    - A write requested in the same cycle as clr_req is dropped.
  - CLEAR:
    - Each cycle reg[counter] <= 0, counter <= counter+1. busy=1.
    - When counter == 2**NB_SEL-1, that register is cleared, state -> DONE.
    - Takes exactly 2**NB_SEL cycles.
  - DONE:
    - clr_done=1 for one cycle, busy=0, then -> IDLE.
- During CLEAR/DONE:
  - wr_en is ignored (write lost, no stall).
  - Bypass is disabled.
  - Reads continue to return current storage contents. Partially cleared values are visible.
- clr_req while busy or in DONE is ignored; there is no restart.
- Counter is NB_SEL+0 bits. Termination is by compare, not by wrap; the counter resets to 0 on entry to CLEAR.
- rst_n low mid-clear aborts immediately: all registers go to 0, IDLE, no clr_done pulse.
- Simultaneous reads of the same address on both ports are legal and return identical data.

Test Plan:
- Reset, then sweep rd_addr_a over 0..7 -> rd_data_a=0 for all; busy=0, clr_done=0.
- Write 0xA5 to reg 3, 0x3C to reg 7 on successive cycles, then read A=3, B=7 -> 0xA5 / 0x3C. Write 0xFF to reg 0 -> reads 0 (ZERO_REG=1).
- Bypass: wr_en=1, wr_addr=5, wr_data=0x5A, rd_addr_a=5 in the same cycle, reg5 previously 0x11 -> rd_data_a=0x5A before the edge. With BYPASS=0 -> 0x11, then 0x5A after the edge.
- Fill regs 1..7 with 0x10..0x70, pulse clr_req:
  - busy=1 for 8 cycles, reg k reads 0 from cycle k+1.
  - clr_done pulses once in cycle 9, then busy=0 and all registers read 0.
- During CLEAR, wr_en=1 to reg 6 with 0x99 -> reg 6 still 0 after clr_done. clr_req re-pulsed mid-clear -> single clr_done, total 8 busy cycles.
- Assert rst_n=0 asynchronously at CLEAR cycle 4 with regs 4..7 nonzero -> busy drops without a clock edge, all reads 0, no clr_done. Normal writes work after release.
